arbitrated_multiplexer: RTL and testbench
=========================================

// Module: arbitrated_multiplexer
// PURPOSE
//  N-input registered multiplexer with valid/ready handshake. Arbitrates among
//  requesting channels by round-robin or fixed priority and holds one output
//  word in a register stage. Flags senders that withdraw a pending request
//  through a sticky error. Used where several producers share one datapath.
// PARAMETERS
//  width     8  data bits per channel
//  channels  4  number of input channels (>=2)
//  priority  0  0: round-robin arbitration; 1: fixed priority, channel 0 highest
// PORTS
//  clk       in   1               clock, all state updates on rising edge
//  rst       in   1               synchronous reset, active-high
//  i_data    in   width*channels  channel k occupies bits [k*width +: width]
//  i_valid   in   channels        per-channel request
//  o_ready   out  channels        per-channel accept; one-hot or zero
//  o_data    out  width           registered output word
//  o_valid   out  1               o_data holds a word
//  i_ready   in   1               downstream accepts o_data
//  o_grant   out  channels        one-hot source of current o_data; zero when empty
//  o_error   out  1               sticky protocol-violation flag
// BEHAVIOUR
//  - Reset: o_data=0, o_valid=0, o_grant=0, o_error=0, round-robin pointer=0.
//    o_ready=0 during reset. Reset mid-transfer discards the held word.
//  - Slot free when !o_valid or (o_valid & i_ready). Same-cycle drain-and-refill
//    is allowed, giving one word per clock throughput.
//  - When the slot is free, one requesting channel g is picked combinationally.
//    o_ready[g]=1 in that cycle. On the edge, o_data<=data[g], o_valid<=1,
//    o_grant<=onehot(g). Latency is one clock, input handshake to o_valid.
//  - If the slot is free and no channel requests: o_valid<=0, o_grant<=0,
//    o_data holds its value.
//  - While o_valid & !i_ready: o_data, o_grant and o_valid hold. o_ready=0.
//  - Round-robin (priority=0): search starts at the pointer and wraps mod
//    channels. After a grant to g, pointer<=(g+1) mod channels; it wraps from
//    channels-1 to 0. The pointer is unchanged when nothing is granted.
//  - Fixed (priority=1): the lowest-index requesting channel wins. No pointer.
//  - Error: per channel, a request is pending when i_valid[k] was 1 in the
//    previous cycle and o_ready[k] was 0. If i_valid[k] is 0 in the current
//    cycle, o_error<=1 on that edge. It stays 1 until rst.
//  - i_data of non-granted channels is ignored. X on those lanes must not
//    propagate to o_data.
// STRUCTURE
//  - Shared package: priority mode constants (ROUND_ROBIN=0, FIXED=1).
//  - Sub-module rr_arbiter (params channels, priority):
//    inputs request vector, pointer, enable; outputs one-hot grant and index.
//  - Top level holds the output register, pointer, previous-cycle valid and
//    ready registers, and the error logic. Data selection is an AND-OR of
//    grant and lanes.
// TESTING (width=3, channels=4; lane k data = k+1)
//  - Reset: assert rst 2 clks with i_valid=4'b1111 -> all outputs 0,
//    o_ready=0, o_error=0.
//  - Single request i_valid=4'b0100, i_ready=1 -> o_ready=4'b0100 same cycle;
//    next clk o_data=3'b011, o_valid=1, o_grant=4'b0100.
//  - Round-robin, all four request continuously, i_ready=1 -> o_data sequence
//    1,2,3,4,1 on successive clocks; pointer wraps 3->0.
//  - Fixed priority (priority=1), i_valid=4'b1110 held 3 clks -> o_data=2
//    every clk; channels 2 and 3 are never granted.
//  - Backpressure: i_ready=0 for 3 clks with o_valid=1 -> o_data and o_grant
//    stable, o_ready=0; then i_ready=1 -> next word the following clk.
//  - Withdrawal: under backpressure, drop i_valid[1] without a grant ->
//    o_error=1 next clk. It stays 1 until rst, then reads 0.

Source files
------------

// File: rtl/arbitrated_multiplexer_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package arbitrated_multiplexer_pkg;

    // Arbitration mode selectors
    localparam int ROUND_ROBIN = 0;
    localparam int FIXED       = 1;

    // Successor of a channel index, wrapping from n-1 back to 0
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbitrated_multiplexer_rr_arbiter.sv
// Picks one requester: rotating search from ptr, or lowest index in fixed mode.
// Latency: purely combinational.
// Backpressure: en=0 forces an all-zero grant.
module rr_arbiter
    import arbitrated_multiplexer_pkg::*;
#(
    parameter int channels      = 4,
    parameter int priority_mode = ROUND_ROBIN
) (
    input  logic [channels-1:0]         req,
    input  logic [$clog2(channels)-1:0] ptr,
    input  logic                        en,
    output logic [channels-1:0]         grant,
    output logic [$clog2(channels)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(channels);

    logic [IDX_W:0]   cand_w;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the channels in search order and take the first requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_w    = '0;
        cand      = '0;
        for (int i = 0; i < channels; i++) begin
            if (priority_mode == FIXED) begin
                cand_w = (IDX_W+1)'(i);
            end else begin
                cand_w = {1'b0, ptr} + (IDX_W+1)'(i);
                if (cand_w >= (IDX_W+1)'(channels)) begin
                    cand_w = cand_w - (IDX_W+1)'(channels);
                end
            end
            cand = cand_w[IDX_W-1:0];
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// N-input registered mux with arbitration and sticky request-withdrawal error.
// Latency: one clock from input handshake to o_valid.
// Backpressure: while o_valid & !i_ready the word holds and all o_ready stay 0.
module arbitrated_multiplexer
    import arbitrated_multiplexer_pkg::*;
#(
    parameter int width         = 8,
    parameter int channels      = 4,
    parameter int priority_mode = ROUND_ROBIN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [width*channels-1:0] i_data,
    input  logic [channels-1:0]       i_valid,
    output logic [channels-1:0]       o_ready,
    output logic [width-1:0]          o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [channels-1:0]       o_grant,
    output logic                      o_error
);
    localparam int IDX_W = $clog2(channels);

    logic                slot_free;
    logic                arb_en;
    logic [channels-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [width-1:0]    sel_data;
    logic [channels-1:0] prev_valid;
    logic [channels-1:0] prev_ready;
    logic                withdrawn;

    // The slot can take a word when empty or draining this cycle
    assign slot_free = !o_valid || i_ready;
    assign arb_en    = slot_free && !rst;
    assign o_ready   = grant;

    rr_arbiter #(
        .channels      (channels),
        .priority_mode (priority_mode)
    ) u_arb (
        .req       (i_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // AND-OR select so unknowns on non-granted lanes are masked off
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < channels; k++) begin
            sel_data = sel_data | ({width{grant[k]}} & i_data[k*width +: width]);
        end
    end

    // A request left unanswered last cycle that is gone now is a violation
    assign withdrawn = |(prev_valid & ~prev_ready & ~i_valid);

    // Output register, arbitration pointer and protocol history
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_grant    <= '0;
            o_error    <= 1'b0;
            rr_ptr     <= '0;
            prev_valid <= '0;
            prev_ready <= '0;
        end else begin
            if (slot_free) begin
                if (|grant) begin
                    o_data  <= sel_data;
                    o_valid <= 1'b1;
                    o_grant <= grant;
                    if (priority_mode == ROUND_ROBIN) begin
                        rr_ptr <= IDX_W'(next_index(int'(grant_idx), channels));
                    end
                end else begin
                    o_valid <= 1'b0;
                    o_grant <= '0;
                end
            end
            if (withdrawn) begin
                o_error <= 1'b1;
            end
            prev_valid <= i_valid;
            prev_ready <= grant;
        end
    end

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
module tb_arbitrated_multiplexer;
    import arbitrated_multiplexer_pkg::*;

    localparam int W = 3;
    localparam int N = 4;

    // Stimulus shapes
    localparam int P_RESET = 0;
    localparam int P_SINGLE = 1;
    localparam int P_IDLE = 2;
    localparam int P_ALL = 3;
    localparam int P_1110 = 4;
    localparam int P_STALL = 5;
    localparam int P_ONE0 = 6;
    localparam int P_WDA = 7;
    localparam int P_WDB = 8;
    localparam int P_RAND = 9;

    localparam int NSTEP = 18;
    int ph_tab  [NSTEP] = '{P_RESET, P_SINGLE, P_IDLE, P_RESET, P_ALL, P_STALL, P_ALL, P_RESET,
                            P_1110, P_IDLE, P_RESET, P_ONE0, P_WDA, P_WDB, P_IDLE, P_RESET,
                            P_IDLE, P_RAND};
    int len_tab [NSTEP] = '{2, 1, 2, 1, 6, 3, 3, 1,
                            3, 1, 1, 1, 2, 1, 3, 2,
                            2, 1500};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: round-robin instance, index 1: fixed-priority instance
    logic                     rst;
    logic [1:0][W*N-1:0]      i_data;
    logic [1:0][N-1:0]        i_valid;
    logic [1:0]               i_ready;
    wire  [1:0][N-1:0]        o_ready;
    wire  [1:0][W-1:0]        o_data;
    wire  [1:0]               o_valid;
    wire  [1:0][N-1:0]        o_grant;
    wire  [1:0]               o_error;

    arbitrated_multiplexer #(.width(W), .channels(N), .priority_mode(ROUND_ROBIN)) dut_rr (
        .clk(clk), .rst(rst), .i_data(i_data[0]), .i_valid(i_valid[0]), .o_ready(o_ready[0]),
        .o_data(o_data[0]), .o_valid(o_valid[0]), .i_ready(i_ready[0]), .o_grant(o_grant[0]),
        .o_error(o_error[0]));

    arbitrated_multiplexer #(.width(W), .channels(N), .priority_mode(FIXED)) dut_fx (
        .clk(clk), .rst(rst), .i_data(i_data[1]), .i_valid(i_valid[1]), .o_ready(o_ready[1]),
        .o_data(o_data[1]), .o_valid(o_valid[1]), .i_ready(i_ready[1]), .o_grant(o_grant[1]),
        .o_error(o_error[1]));

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: held-word flag, rotation start, sticky error, last-cycle requests/accepts
    logic        mv   [2];
    int          mptr [2];
    logic        merr [2];
    logic [N-1:0] pv  [2];
    logic [N-1:0] pr  [2];
    int          idle_data [2];
    // Expected output words: data in low W bits, one-hot source above
    int q0 [$];
    int q1 [$];

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, m, $time, act, exp);
        end
    endtask

    task automatic rand_inputs(input int m);
        logic [N-1:0] pend;
        pend = pv[m] & ~pr[m];
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                // A waiting producer normally holds its word; rarely it backs out
                if ($urandom_range(0, 99) < 96) begin
                    i_valid[m][k] = 1'b1;
                end else begin
                    i_valid[m][k] = 1'b0;
                    i_data[m][k*W +: W] = 'x;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                i_valid[m][k] = 1'b1;
                i_data[m][k*W +: W] = W'($urandom_range(0, 7));
            end else begin
                i_valid[m][k] = 1'b0;
                i_data[m][k*W +: W] = 'x;
            end
        end
        i_ready[m] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic apply(input int ph);
        logic [N-1:0] pat;
        logic         rdy;
        rst = (ph == P_RESET) || (ph == P_RAND && $urandom_range(0, 149) == 0);
        pat = '0;
        rdy = 1'b1;
        case (ph)
            P_RESET:  pat = 4'b1111;
            P_SINGLE: pat = 4'b0100;
            P_ALL:    pat = 4'b1111;
            P_1110:   pat = 4'b1110;
            P_STALL:  begin pat = 4'b1111; rdy = 1'b0; end
            P_ONE0:   pat = 4'b0001;
            P_WDA:    begin pat = 4'b0010; rdy = 1'b0; end
            P_WDB:    begin pat = 4'b0000; rdy = 1'b0; end
            default:  pat = 4'b0000;
        endcase
        for (int m = 0; m < 2; m++) begin
            if (ph == P_RAND) begin
                rand_inputs(m);
            end else begin
                i_valid[m] = pat;
                i_ready[m] = rdy;
                for (int k = 0; k < N; k++) begin
                    if (pat[k]) i_data[m][k*W +: W] = W'(k + 1);
                    else        i_data[m][k*W +: W] = 'x;
                end
            end
        end
    endtask

    // Evaluate one cycle of the reference: who must be accepted, what gets loaded
    task automatic model_step(input int m);
        logic [N-1:0] exp_rdy;
        int           g;
        int           c;
        exp_rdy = '0;
        g = -1;
        check("o_error", m, 32'(o_error[m]), 32'(merr[m]));
        if (rst) begin
            check("o_ready_in_reset", m, 32'(o_ready[m]), 32'd0);
            mv[m] = 1'b0;
            mptr[m] = 0;
            merr[m] = 1'b0;
            pv[m] = '0;
            pr[m] = '0;
            idle_data[m] = 0;
            if (m == 0) q0.delete();
            else        q1.delete();
            return;
        end
        if (!mv[m] || i_ready[m]) begin
            for (int i = 0; i < N; i++) begin
                c = (m == 1) ? i : (mptr[m] + i) % N;
                if (g < 0 && i_valid[m][c]) g = c;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                if (m == 0) q0.push_back(int'(i_data[m][g*W +: W]) | ((1 << g) << W));
                else        q1.push_back(int'(i_data[m][g*W +: W]) | ((1 << g) << W));
                mv[m] = 1'b1;
                if (m == 0) mptr[m] = (g + 1) % N;
            end else begin
                mv[m] = 1'b0;
            end
        end
        check("o_ready", m, 32'(o_ready[m]), 32'(exp_rdy));
        for (int k = 0; k < N; k++) begin
            if (pv[m][k] && !pr[m][k] && !i_valid[m][k]) merr[m] = 1'b1;
        end
        pv[m] = i_valid[m];
        pr[m] = exp_rdy;
    endtask

    // Monitor: compare the presented word against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                int qs;
                int head;
                qs = (m == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    check("o_valid_empty", m, 32'(o_valid[m]), 32'd0);
                    check("o_grant_empty", m, 32'(o_grant[m]), 32'd0);
                    check("o_data_hold", m, 32'(o_data[m]), 32'(idle_data[m]));
                end else begin
                    head = (m == 0) ? q0[0] : q1[0];
                    check("o_valid", m, 32'(o_valid[m]), 32'd1);
                    check("o_data", m, 32'(o_data[m]), 32'(head & 7));
                    check("o_grant", m, 32'(o_grant[m]), 32'(head >> W));
                    if (i_ready[m]) begin
                        idle_data[m] = head & 7;
                        if (m == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus and reference model
    initial begin
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0;
            mptr[m] = 0;
            merr[m] = 1'b0;
            pv[m] = '0;
            pr[m] = '0;
            idle_data[m] = 0;
        end
        apply(P_RESET);
        for (int s = 0; s < NSTEP; s++) begin
            for (int c = 0; c < len_tab[s]; c++) begin
                apply(ph_tab[s]);
                @(negedge clk);
                #1;
                model_step(0);
                model_step(1);
                @(posedge clk);
                #1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
